// File: rtl/bit_stuff_pkg.sv
// rtl/bit_stuff_pkg.sv - shared state encoding and defaults for the bit-stuffing transmitter
package bit_stuff_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } state_t;

endpackage

// File: rtl/run_tracker.sv
// rtl/run_tracker.sv - run-length history of transmitted bits; flags when a stuff bit is due
module run_tracker (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_bit_valid,
    input  logic i_bit,
    output logic o_need_stuff
);

    logic       r_last_bit;
    logic [1:0] r_run_cnt;

    // run_cnt of 0 means empty history, so the first bit after a clear always starts a new run
    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_last_bit <= 1'b0;
            r_run_cnt  <= 2'd0;
        end else if (i_bit_valid) begin
            if (r_run_cnt != 2'd0 && i_bit == r_last_bit) begin
                r_run_cnt <= 2'd2;
            end else begin
                r_run_cnt <= 2'd1;
            end
            r_last_bit <= i_bit;
        end
    end

    assign o_need_stuff = (r_run_cnt == 2'd2);

endmodule

// File: rtl/bit_stuff_tx.sv
// rtl/bit_stuff_tx.sv - MSB-first serialiser inserting a complemented bit after every run of two
module bit_stuff_tx
    import bit_stuff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             stuff,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_x_valid;
    logic             w_x_valid_nxt;
    logic             r_stuff;
    logic             w_stuff_nxt;
    logic             r_trail;
    logic             w_trail_nxt;

    logic             w_need_stuff;
    logic             w_last_data;
    logic             w_ready;
    logic             w_xfer;
    logic             w_do_load;
    logic             w_do_advance;
    logic             w_do_stuff;
    logic             w_do_idle;
    logic             w_clear;

    assign w_last_data = (r_cnt == LAST_IDX);

    // Ready whenever the bit now on the line is the final bit of the current word's expansion
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            SHIFT:   w_ready = w_last_data && !w_need_stuff;
            STUFF:   w_ready = r_trail;
            default: w_ready = 1'b0;
        endcase
        if (!rst) begin
            w_ready = 1'b0;
        end
    end

    assign w_xfer = load_valid && w_ready;

    always_comb begin
        w_do_load    = 1'b0;
        w_do_advance = 1'b0;
        w_do_stuff   = 1'b0;
        w_do_idle    = 1'b0;
        case (r_state)
            IDLE: begin
                w_do_load = w_xfer;
            end
            SHIFT: begin
                if (w_need_stuff) begin
                    w_do_stuff = 1'b1;
                end else if (!w_last_data) begin
                    w_do_advance = 1'b1;
                end else if (w_xfer) begin
                    w_do_load = 1'b1;
                end else begin
                    w_do_idle = 1'b1;
                end
            end
            STUFF: begin
                if (!r_trail) begin
                    w_do_advance = 1'b1;
                end else if (w_xfer) begin
                    w_do_load = 1'b1;
                end else begin
                    w_do_idle = 1'b1;
                end
            end
            default: begin
                w_do_idle = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_x_nxt       = r_x;
        w_x_valid_nxt = r_x_valid;
        w_stuff_nxt   = r_stuff;
        w_trail_nxt   = r_trail;
        if (w_do_load) begin
            w_state_nxt   = SHIFT;
            w_x_nxt       = load_data[WIDTH-1];
            w_shift_nxt   = {load_data[WIDTH-2:0], 1'b0};
            w_cnt_nxt     = '0;
            w_x_valid_nxt = 1'b1;
            w_stuff_nxt   = 1'b0;
            w_trail_nxt   = 1'b0;
        end else if (w_do_advance) begin
            w_state_nxt   = SHIFT;
            w_x_nxt       = r_shift[WIDTH-1];
            w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
            w_cnt_nxt     = r_cnt + CW'(1);
            w_x_valid_nxt = 1'b1;
            w_stuff_nxt   = 1'b0;
            w_trail_nxt   = 1'b0;
        end else if (w_do_stuff) begin
            w_state_nxt   = STUFF;
            w_x_nxt       = ~r_x;
            w_x_valid_nxt = 1'b1;
            w_stuff_nxt   = 1'b1;
            w_trail_nxt   = w_last_data;
        end else if (w_do_idle) begin
            w_state_nxt   = IDLE;
            w_x_nxt       = 1'b0;
            w_cnt_nxt     = '0;
            w_x_valid_nxt = 1'b0;
            w_stuff_nxt   = 1'b0;
            w_trail_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_stuff   <= 1'b0;
            r_trail   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_stuff   <= w_stuff_nxt;
            r_trail   <= w_trail_nxt;
        end
    end

    // History follows the bit that will be on the line next cycle; idle wipes it
    assign w_clear = (w_state_nxt == IDLE);

    run_tracker u_run_tracker (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_bit_valid  (w_x_valid_nxt),
        .i_bit        (w_x_nxt),
        .o_need_stuff (w_need_stuff)
    );

    assign load_ready = w_ready;
    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign stuff      = r_stuff;
    assign busy       = (r_state != IDLE);

endmodule
